// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg -- shared definitions for the audio path (tone generator and
// PWM output stage).
//   AUDIO_WIDTH     : default signed sample width in bits
//   sample_t        : two's-complement sample as produced by the tone generator
//   duty_t          : unsigned PWM duty (offset-binary form of a sample)
//   sample_to_duty  : offset-binary conversion (MSB inversion)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_WIDTH = 7;

    typedef logic signed [AUDIO_WIDTH-1:0] sample_t;
    typedef logic        [AUDIO_WIDTH-1:0] duty_t;

    // Adding 2^(W-1) to a two's-complement value is the same as flipping its
    // MSB, so the most negative sample maps to duty 0 and zero to mid-scale.
    function automatic duty_t sample_to_duty(input sample_t s);
        return {~s[AUDIO_WIDTH-1], s[AUDIO_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo -- small synchronous FIFO buffering samples ahead of the PWM.
//   clk, reset_n : clock, asynchronous active-low reset (clears pointers)
//   push, wdata  : write request / data (ignored while full)
//   pop          : read request (ignored while empty)
//   rdata        : head-of-queue data, valid whenever !empty
//   full, empty  : status, decoded from registered pointers only
//   fill         : occupancy 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop  & ~empty;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign fill  = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/audio_pwm_out.sv
// -----------------------------------------------------------------------------
// audio_pwm_out -- buffers signed audio samples and plays them as a PWM
// speaker drive, one sample per 2^WIDTH-clock period.
//   clk, reset_n   : clock, asynchronous active-low reset
//   en             : play enable; low mutes, holds the period counter at 0,
//                    keeps duty and buffered samples, still accepts pushes
//   in_sample      : two's-complement sample, qualified by in_valid
//   in_ready       : sample accepted this cycle when in_valid is also high
//   pwm_out        : registered speaker drive
//   sample_tick    : one-cycle pulse after a sample was taken for a period
//   underrun       : one-cycle pulse after a period started with no sample
//   fill           : buffer occupancy
//   underrun_count : saturating underrun tally
// Build option: AUDIO_PWM_UNDERRUN_CNT_EN builds the 8-bit underrun counter;
// without it underrun_count is tied to 0.
// -----------------------------------------------------------------------------
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int WIDTH      = AUDIO_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [WIDTH-1:0]              in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic [7:0]                    underrun_count
);

    logic [WIDTH-1:0] pcnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             period_start;
    logic             starve;

    // Status comes from registered pointers, so a sample pushed into an
    // empty buffer on a period-start cycle is not visible to that pop.
    assign in_ready     = ~full;
    assign push         = in_valid & ~full;

    // While muted pcnt sits at 0, so the first enabled cycle is a start.
    assign period_start = en & (pcnt == '0);
    assign pop          = period_start & ~empty;
    assign starve       = period_start & empty;

    // Bypass the fresh duty into the compare so the first bit of the new
    // period already reflects the popped sample.
    assign duty_next = pop ? {~head[WIDTH-1], head[WIDTH-2:0]} : duty;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (in_sample),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .fill    (fill)
    );

    // Period counter wraps naturally at 2^WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pcnt <= '0;
        else if (!en)  pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty        <= '0;
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            duty        <= duty_next;
            // Strict compare: duty 0 never drives high, full scale leaves
            // one low clock per period.
            pwm_out     <= en & (pcnt < duty_next);
            sample_tick <= pop;
            underrun    <= starve;
        end
    end

`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
    logic [7:0] urun_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            urun_cnt <= '0;
        else if (starve && (urun_cnt != 8'hFF))
            urun_cnt <= urun_cnt + 8'd1;
    end

    assign underrun_count = urun_cnt;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_out -- self-checking bench for audio_pwm_out. A queue-based
// reference model tracks the buffer, period position and duty and predicts
// every output each cycle; directed sequences and a vector table cover the
// conversion, back-pressure, mute, underrun and reset corner cases.
// -----------------------------------------------------------------------------
module tb_audio_pwm_out;
    import audio_pkg::*;

    localparam int W      = AUDIO_WIDTH;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1 << W;
    localparam int HALF   = 1 << (W - 1);

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       en = 1'b0;
    logic                       in_valid = 1'b0;
    sample_t                    in_sample = '0;
    logic                       in_ready;
    logic                       pwm_out;
    logic                       sample_tick;
    logic                       underrun;
    logic [$clog2(DEPTH):0]     fill;
    logic [7:0]                 underrun_count;

    always #5 clk = ~clk;

    audio_pwm_out #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pwm_out        (pwm_out),
        .sample_tick    (sample_tick),
        .underrun       (underrun),
        .fill           (fill),
        .underrun_count (underrun_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int q[$];
    int pc    = 0;
    int duty  = 0;
    int e_cnt = 0;
    bit e_pwm = 0, e_tick = 0, e_und = 0;

    typedef struct {
        int smp;
        int high;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pc = 0; duty = 0; e_cnt = 0;
        e_pwm = 0; e_tick = 0; e_und = 0;
    endtask

    task automatic check_all();
        chk("pwm_out", int'(pwm_out), int'(e_pwm));
        chk("sample_tick", int'(sample_tick), int'(e_tick));
        chk("underrun", int'(underrun), int'(e_und));
        chk("fill", int'(fill), q.size());
        chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
        chk("underrun_count", int'(underrun_count), e_cnt);
    endtask

    // One clock: model the edge from the inputs present, then compare.
    task automatic step();
        int  sz, nd;
        bit  start, pop, psh;
        @(posedge clk);
        sz    = q.size();
        start = en && (pc == 0);
        pop   = start && (sz > 0);
        nd    = pop ? (q[0] + HALF) : duty;
        e_pwm  = en && (pc < nd);
        e_tick = pop;
        e_und  = start && (sz == 0);
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
        if (e_und && e_cnt < 255) e_cnt++;
`endif
        psh = in_valid && (sz < DEPTH);
        if (pop) void'(q.pop_front());
        if (psh) q.push_back(int'(in_sample));
        duty = nd;
        pc   = en ? ((pc + 1) % PERIOD) : 0;
        #1;
        check_all();
    endtask

    task automatic run_until_tick(input string nm, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (sample_tick) begin ok = 1; break; end
        end
        chk({nm, "_tick_seen"}, int'(ok), 1);
    endtask

    // High clocks over one period, the current cycle being its first.
    task automatic measure_high(output int h);
        h = int'(pwm_out);
        repeat (PERIOD - 1) begin
            step();
            h += int'(pwm_out);
        end
    endtask

    task automatic push_one(input int s);
        in_valid  = 1'b1;
        in_sample = sample_t'(s);
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, uc;

        tv[0] = '{smp: -64, high: 0};
        tv[1] = '{smp:   0, high: 64};
        tv[2] = '{smp:  63, high: 127};
        tv[3] = '{smp:  -1, high: 63};
        tv[4] = '{smp:   1, high: 65};
        tv[5] = '{smp: -33, high: 31};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_und", int'(underrun), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_cnt", int'(underrun_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Most negative sample plays as constant low.
        en = 1'b1;
        push_one(-64);
        run_until_tick("neg", 2 * PERIOD + 2);
        measure_high(h);
        chk("neg_high", h, 0);

        // Conversion table.
        foreach (tv[i]) begin
            push_one(tv[i].smp);
            run_until_tick("tv", 2 * PERIOD + 2);
            measure_high(h);
            chk($sformatf("tv%0d_high", i), h, tv[i].high);
        end

        // Two consecutive periods.
        push_one(0);
        push_one(63);
        run_until_tick("seq", 2 * PERIOD + 2);
        measure_high(h);
        chk("seq_p1_high", h, 64);
        step();
        chk("seq_p2_tick", int'(sample_tick), 1);
        measure_high(h);
        chk("seq_p2_high", h, 127);

        // Back-pressure with in_valid held.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sample = sample_t'(10 * (k + 1));
            step();
        end
        chk("bp_fill", int'(fill), 4);
        chk("bp_ready", int'(in_ready), 0);
        in_sample = sample_t'(50);
        run_until_tick("bp", PERIOD + 2);
        chk("bp_fill_pop", int'(fill), 3);
        chk("bp_ready_pop", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("bp_fill_5th", int'(fill), 4);

        // Mute mid-period with two samples buffered.
        run_until_tick("mute_a", PERIOD + 2);
        run_until_tick("mute_b", PERIOD + 2);
        chk("mute_fill_pre", int'(fill), 2);
        repeat (10) step();
        en = 1'b0;
        step();
        chk("mute_pwm", int'(pwm_out), 0);
        chk("mute_fill", int'(fill), 2);
        repeat (20) step();
        chk("mute_fill_hold", int'(fill), 2);
        en = 1'b1;
        step();
        chk("unmute_tick", int'(sample_tick), 1);

        // Drain, then 300 starved periods repeating the last duty (50).
        run_until_tick("drain", PERIOD + 2);
        uc = 0;
        for (int i = 0; i < 302 * PERIOD && uc < 300; i++) begin
            step();
            if (underrun) uc++;
        end
        chk("und_pulses", uc, 300);
`ifdef AUDIO_PWM_UNDERRUN_CNT_EN
        chk("und_count", int'(underrun_count), 255);
`else
        chk("und_count", int'(underrun_count), 0);
`endif
        measure_high(h);
        chk("und_repeat_high", h, 50 + HALF);

        // Asynchronous reset mid-period with three samples buffered.
        en = 1'b0;
        in_valid = 1'b1;
        in_sample = sample_t'(60);
        repeat (4) step();
        in_valid = 1'b0;
        en = 1'b1;
        step();
        repeat (20) step();
        chk("arst_fill_pre", int'(fill), 3);
        chk("arst_pwm_pre", int'(pwm_out), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_tick", int'(sample_tick), 0);
        chk("arst_und", int'(underrun), 0);
        chk("arst_fill", int'(fill), 0);
        chk("arst_cnt", int'(underrun_count), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_ready", int'(in_ready), 1);
        step();
        chk("arst_restart_und", int'(underrun), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            in_valid  = ($urandom_range(0, 99) < 3);
            in_sample = sample_t'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 SHALL have parameter WIDTH, default 7, meaning the signed sample width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning the sample buffer entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: play enable; low = mute.
REQ-006 SHALL have port in_sample, input, WIDTH bits: two's-complement sample from the tone generator.
REQ-007 SHALL have port in_valid, input, 1 bit: in_sample is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port pwm_out, output, 1 bit: registered speaker drive.
REQ-010 SHALL have port sample_tick, output, 1 bit: one-cycle pulse when a sample is popped.
REQ-011 SHALL have port underrun, output, 1 bit: one-cycle pulse when a period starts with the FIFO empty.
REQ-012 SHALL have port fill, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port underrun_count, output, 8 bits: saturating underrun tally (see Configuration).

Function
REQ-014 SHALL assert in_ready = (fill != FIFO_DEPTH), combinationally from registered state only.
REQ-015 SHALL push in_sample when in_valid && in_ready; data SHALL be held until popped.
REQ-016 SHALL run a WIDTH-bit period counter pcnt, 0..2^WIDTH-1, wrapping; one PWM period = 2^WIDTH clocks.
REQ-017 SHALL, in the cycle pcnt==0 with en high: pop if fill>0 (sample_tick=1), else keep the previous duty (underrun=1).
REQ-018 SHALL convert a popped sample to duty by inverting its MSB (offset binary): -2^(WIDTH-1) -> 0, 0 -> 2^(WIDTH-1), 2^(WIDTH-1)-1 -> 2^WIDTH-1.
REQ-019 SHALL apply a new duty to the period starting on the cycle after the pop; pwm_out SHALL be high when pcnt < duty (registered, 1-cycle latency from pcnt).
REQ-020 SHALL give duty 0 as constant low, and duty 2^WIDTH-1 as high for 2^WIDTH-1 of 2^WIDTH clocks.
REQ-021 SHALL, on simultaneous push and pop, update fill by zero; a push into an empty FIFO in the same cycle as pcnt==0 SHALL NOT be popped that cycle (underrun reported).
REQ-022 SHALL, when en is low: hold pcnt at 0, force pwm_out 0, suppress pops/ticks/underruns, keep duty and FIFO contents, and still accept pushes.
REQ-023 SHALL, when en rises, treat the first cycle as pcnt==0 (pop or underrun per REQ-017).
REQ-024 SHALL implement FIFO read/write pointers with one extra wrap bit; no data loss at full or at pointer wrap.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear pcnt, pointers, fill, duty (to 0), pwm_out, sample_tick, underrun and underrun_count; in_ready SHALL read 1 after reset.
REQ-026 SHALL, on reset mid-period, discard all buffered samples and restart at pcnt==0 after reset release.

Configuration
REQ-027 SHALL use macro AUDIO_PWM_UNDERRUN_CNT_EN: when defined, underrun_count increments on each underrun pulse, saturating at 255; when undefined, underrun_count SHALL be constant 0 and no counter logic is built.

Structure
REQ-028 SHALL take WIDTH default, sample_t (logic signed [WIDTH-1:0]) and duty_t typedefs from shared package audio_pkg, used also by the tone generator.
REQ-029 SHALL place the buffer in sub-module sample_fifo (push/pop/full/empty/fill); PWM counter and duty logic SHALL stay in audio_pwm_out.

Verification
REQ-030 SHALL check: reset, en=1, push -64 (0x40) -> one sample_tick at the next pcnt==0, pwm_out low for the following 128 clocks.
REQ-031 SHALL check: push 0 then 63 -> high time 64 clocks in the first period, 127 clocks in the second.
REQ-032 SHALL check: 5 back-to-back pushes with in_valid held -> in_ready drops after 4, fill=4, 5th held until the first pop, then accepted.
REQ-033 SHALL check: empty FIFO at pcnt==0 -> underrun pulse, previous duty repeated; with AUDIO_PWM_UNDERRUN_CNT_EN, 300 underruns -> underrun_count=255; without it, 0.
REQ-034 SHALL check: en low mid-period with fill=2 -> pwm_out 0 next cycle, fill stays 2; en high -> immediate sample_tick.
REQ-035 SHALL check: reset_n asserted with fill=3 mid-period -> all outputs 0 asynchronously, fill=0, in_ready=1 after release.
